button_pulse_conditioner: RTL
=============================

Name: button_pulse_conditioner

Overview:
- Upstream front-end for the PWM duty-cycle stage.
- Takes the two raw, bouncing push-button inputs (increase, decrease), synchronises and debounces them, and emits clean single-cycle duty_inc / duty_dec pulses.
- Optional hold-to-repeat auto-fire and mutual-exclusion arbitration.
- Outputs connect directly to the PWM stage's increment/decrement inputs.

Parameters:
- TICK_DIV, 250000, clk cycles per debounce sample tick (>=2; 4 in simulation).
- STABLE_CNT, 4, consecutive differing ticks required before the debounced level flips (>=1).
- REPEAT_DLY, 8, ticks from the initial press pulse to the first auto-repeat pulse (>=1).
- REPEAT_RATE, 2, ticks between successive auto-repeat pulses (>=1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- btn_inc_raw  in  1  raw asynchronous increase button, active high.
- btn_dec_raw  in  1  raw asynchronous decrease button, active high.
- en_repeat  in  1  1 = hold-to-repeat enabled (sampled on ticks).
- duty_inc  out  1  registered one-cycle increase pulse.
- duty_dec  out  1  registered one-cycle decrease pulse.
- inc_level  out  1  debounced increase button level.
- dec_level  out  1  debounced decrease button level.
- tick  out  1  registered one-cycle sample-tick strobe.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0. Synchronisers, debounced levels and counters cleared; both FSMs in IDLE.
- Synchroniser: 2-FF per raw input. Logic uses only the second-stage value (s_inc, s_dec).
- Tick counter:
  - Width $clog2(TICK_DIV); counts 0..TICK_DIV-1 and wraps.
  - tick=1 for the one cycle when the counter equals TICK_DIV-1. The first tick after reset lands on cycle TICK_DIV-1.
- Debounce, per channel, evaluated only on tick cycles:
  - If sampled value == level: stable counter <= 0.
  - Otherwise counter increments. When the incremented value reaches STABLE_CNT, level flips and the counter clears.
  - A glitch shorter than STABLE_CNT ticks never changes the level.
- Rise event: a level 0->1 transition on a tick edge. Output pulses are registered; a pulse is high exactly one cycle, starting the cycle after the edge at which its cause was recognised.
- Arbitration:
  - A pulse on a channel is issued only if the other channel's post-update level is 0.
  - Simultaneous rises on the same tick: no pulse on either channel.
  - While both levels are 1, neither channel issues a pulse and both FSMs sit in HOLD.
  - duty_inc and duty_dec are never high in the same cycle.
- Per-channel FSM (IDLE, DELAY, REPEAT, HOLD); repeat counters advance only on ticks.
  - IDLE: on rise with the pulse granted, issue the pulse. Then go to DELAY if en_repeat=1, else HOLD. Repeat counter cleared.
  - IDLE, rise not granted: go to HOLD, no pulse.
  - DELAY: counter increments each tick. On reaching REPEAT_DLY: issue pulse, clear counter, go to REPEAT.
  - REPEAT: on each REPEAT_RATE-th tick, issue pulse and clear counter.
  - DELAY/REPEAT with en_repeat=0, or other level=1, on a tick: go to HOLD, no pulse, counter cleared.
  - HOLD: no pulses. Re-entry to DELAY from HOLD is not possible; a fresh press is required.
  - Any state: level falls -> IDLE, counter cleared, same tick.
- Reset mid-operation: any pending pulse is dropped and outputs return to 0 the next cycle. A button still held when reset is released must re-debounce, since the level restarts at 0, and then yields one normal rise.
- Latency: a clean press is recognised on tick number STABLE_CNT after the synchronised value changes. It is +2 cycles for the synchroniser, plus up to TICK_DIV-1 cycles of tick phase. The pulse follows one cycle later.

Test Plan (TICK_DIV=4, STABLE_CNT=3, REPEAT_DLY=4, REPEAT_RATE=2):
- Reset, hold rst=1 for 3 cycles -> all outputs 0; tick first asserted at cycle 3 after release, then every 4 cycles.
- Clean press of btn_inc_raw held for 40 cycles, en_repeat=0 -> inc_level rises after 3 ticks; exactly one duty_inc pulse of 1 cycle; duty_dec stays 0; release -> inc_level falls 3 ticks later with no pulse.
- Bouncing press toggling every 3 cycles for 20 cycles, then held high -> no pulse during the bounce; exactly one duty_inc pulse, after 3 consecutive high ticks.
- btn_dec_raw held for 80 cycles, en_repeat=1 -> initial duty_dec pulse, a second pulse 4 ticks (16 cycles) later, then one pulse every 2 ticks (8 cycles) until release; pulses stop within 3 ticks of release.
- Both buttons pressed in the same cycle and held -> both levels rise on the same tick, zero pulses; releasing dec while inc is still held -> still zero pulses (inc in HOLD).
- Assert rst while inc is held in REPEAT -> outputs 0 the cycle after; after rst drops with inc still held, exactly one fresh duty_inc pulse 3 ticks later, repeats resume per schedule.

Source files
------------

// File: rtl/button_pulse_conditioner_if.sv
// Button-side and PWM-side signals of the push-button conditioner.
// The master drives the raw buttons and the repeat enable. The slave returns the pulses, the levels and the tick.
interface button_pulse_conditioner_if;
    logic btn_inc_raw;
    logic btn_dec_raw;
    logic en_repeat;
    logic duty_inc;
    logic duty_dec;
    logic inc_level;
    logic dec_level;
    logic tick;

    modport master (
        output btn_inc_raw, btn_dec_raw, en_repeat,
        input  duty_inc, duty_dec, inc_level, dec_level, tick
    );

    modport slave (
        input  btn_inc_raw, btn_dec_raw, en_repeat,
        output duty_inc, duty_dec, inc_level, dec_level, tick
    );
endinterface

// File: rtl/button_pulse_conditioner.sv
// Synchronises and debounces the inc/dec buttons, then issues single-cycle duty pulses.
// The pulses support hold-to-repeat and mutual-exclusion arbitration. Channel 0 is inc and channel 1 is dec.
//
// state  | meaning
// IDLE   | button released, waiting for a debounced rise
// DELAY  | pressed and pulsed, counting ticks to the first auto-repeat
// REPEAT | auto-repeating every REPEAT_RATE ticks
// HOLD   | pressed but silent until released
module button_pulse_conditioner #(
    parameter int TICK_DIV    = 250000,
    parameter int STABLE_CNT  = 4,
    parameter int REPEAT_DLY  = 8,
    parameter int REPEAT_RATE = 2
) (
    input  logic clk,
    input  logic rst,
    button_pulse_conditioner_if.slave bus
);
    localparam int TW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW   = $clog2(STABLE_CNT + 1);
    localparam int RMAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);
    localparam logic [TW-1:0] TICK_LAST   = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0] STABLE_LAST = SW'(STABLE_CNT);
    localparam logic [RW-1:0] DLY_N       = RW'(REPEAT_DLY);
    localparam logic [RW-1:0] RATE_N      = RW'(REPEAT_RATE);

    typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

    logic [1:0]    sync1, sync2;
    logic [TW-1:0] tick_cnt, tick_cnt_nxt;
    logic          tick_q;
    logic [1:0]    level_q, level_d, rise, fall, other_lvl, fire, pulse_q;
    logic [SW-1:0] stab_q [2];
    logic [SW-1:0] stab_d [2];
    state_t        state_q [2];
    state_t        state_d [2];
    logic [RW-1:0] rcnt_q [2];
    logic [RW-1:0] rcnt_d [2];

    assign tick_cnt_nxt = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            tick_cnt <= '0;
            tick_q   <= 1'b0;
        end else begin
            sync1    <= {bus.btn_dec_raw, bus.btn_inc_raw};
            sync2    <= sync1;
            tick_cnt <= tick_cnt_nxt;
            tick_q   <= (tick_cnt_nxt == TICK_LAST);
        end
    end

    always_comb begin
        level_d = level_q;
        for (int c = 0; c < 2; c++) begin
            stab_d[c] = stab_q[c];
            if (tick_q) begin
                if (sync2[c] == level_q[c]) begin
                    stab_d[c] = '0;
                end else if (stab_q[c] + SW'(1) == STABLE_LAST) begin
                    level_d[c] = ~level_q[c];
                    stab_d[c]  = '0;
                end else begin
                    stab_d[c] = stab_q[c] + SW'(1);
                end
            end
        end
    end

    // Arbitration looks at the other channel's level after this tick's update.
    assign rise      = level_d & ~level_q;
    assign fall      = level_q & ~level_d;
    assign other_lvl = {level_d[0], level_d[1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= '0;
            pulse_q <= '0;
            for (int c = 0; c < 2; c++) begin
                stab_q[c]  <= '0;
                state_q[c] <= IDLE;
                rcnt_q[c]  <= '0;
            end
        end else begin
            level_q <= level_d;
            pulse_q <= fire;
            for (int c = 0; c < 2; c++) begin
                stab_q[c]  <= stab_d[c];
                state_q[c] <= state_d[c];
                rcnt_q[c]  <= rcnt_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_d[c] = state_q[c];
            rcnt_d[c]  = rcnt_q[c];
            if (tick_q) begin
                if (fall[c]) begin
                    state_d[c] = IDLE;
                    rcnt_d[c]  = '0;
                end else begin
                    case (state_q[c])
                        IDLE: if (rise[c]) begin
                            rcnt_d[c]  = '0;
                            state_d[c] = (!other_lvl[c] && bus.en_repeat) ? DELAY : HOLD;
                        end
                        DELAY: if (!bus.en_repeat || other_lvl[c]) begin
                            state_d[c] = HOLD;
                            rcnt_d[c]  = '0;
                        end else if (rcnt_q[c] + RW'(1) == DLY_N) begin
                            state_d[c] = REPEAT;
                            rcnt_d[c]  = '0;
                        end else begin
                            rcnt_d[c] = rcnt_q[c] + RW'(1);
                        end
                        REPEAT: if (!bus.en_repeat || other_lvl[c]) begin
                            state_d[c] = HOLD;
                            rcnt_d[c]  = '0;
                        end else if (rcnt_q[c] + RW'(1) == RATE_N) begin
                            rcnt_d[c] = '0;
                        end else begin
                            rcnt_d[c] = rcnt_q[c] + RW'(1);
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        fire = '0;
        for (int c = 0; c < 2; c++) begin
            if (tick_q && !fall[c] && !other_lvl[c]) begin
                case (state_q[c])
                    IDLE:    fire[c] = rise[c];
                    DELAY:   fire[c] = bus.en_repeat && (rcnt_q[c] + RW'(1) == DLY_N);
                    REPEAT:  fire[c] = bus.en_repeat && (rcnt_q[c] + RW'(1) == RATE_N);
                    default: fire[c] = 1'b0;
                endcase
            end
        end
    end

    assign bus.duty_inc  = pulse_q[0];
    assign bus.duty_dec  = pulse_q[1];
    assign bus.inc_level = level_q[0];
    assign bus.dec_level = level_q[1];
    assign bus.tick      = tick_q;
endmodule
